// File: rtl/ifetch_unit_if.sv
// Bundle of the fetch unit's memory read port, decode-side IF/ID stream and redirect inputs.
// master is the fetch unit; slave is the memory/decode environment.
interface ifetch_unit_if;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;

    logic        id_ready;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    logic [31:0] instr_reg;
    logic [63:0] ifid_npc;
    logic        data_ack;
    logic        halted;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_gnt,
        input  mem_rvalid,
        input  mem_rdata,
        input  id_ready,
        input  redirect_valid,
        input  redirect_pc,
        output instr_reg,
        output ifid_npc,
        output data_ack,
        output halted
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_gnt,
        output mem_rvalid,
        output mem_rdata,
        output id_ready,
        output redirect_valid,
        output redirect_pc,
        input  instr_reg,
        input  ifid_npc,
        input  data_ack,
        input  halted
    );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: 64-bit aligned reads, 32-bit word select, small instruction FIFO,
// redirect flush with stale-response tracking, and halt on the all-zero instruction.
module ifetch_unit #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    ifetch_unit_if.master bus
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {StReq, StWait, StHalt} state_e;

    state_e            state_q, state_d;
    logic [63:0]       pc_q, pc_d;
    logic [63:0]       req_pc_q, req_pc_d;
    logic              stale_q, stale_d;
    logic              halted_q, halted_d;
    logic              started_q;

    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [31:0]       instr_q [FIFO_DEPTH];
    logic [63:0]       npc_q   [FIFO_DEPTH];

    logic              push, pop, flush;
    logic              head_valid;
    logic [31:0]       fetch_word;
    logic [63:0]       fetch_npc;
    logic              unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

    assign fetch_word = req_pc_q[2] ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0];
    assign fetch_npc  = req_pc_q + 64'd4;

    // Only one request is ever in flight and it is issued from StReq, so a free slot
    // at issue time is automatically reserved for its response.
    assign bus.mem_req  = started_q && (state_q == StReq) && !halted_q &&
                          (count_q < CntW'(FIFO_DEPTH));
    assign bus.mem_addr = {pc_q[63:3], 3'b000};

    assign head_valid    = (count_q != '0);
    assign bus.data_ack  = head_valid;
    assign bus.instr_reg = head_valid ? instr_q[rd_ptr_q] : 32'h0;
    assign bus.ifid_npc  = head_valid ? npc_q[rd_ptr_q] : 64'h0;
    assign bus.halted    = halted_q;

    assign pop = head_valid && bus.id_ready && !bus.redirect_valid;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        stale_d  = stale_q;
        halted_d = halted_q;
        push     = 1'b0;
        flush    = 1'b0;

        if (bus.redirect_valid) begin
            flush    = 1'b1;
            pc_d     = {bus.redirect_pc[63:2], 2'b00};
            halted_d = 1'b0;
            if (state_q == StWait && !bus.mem_rvalid) begin
                stale_d = 1'b1;
            end else if (state_q == StReq && bus.mem_req && bus.mem_gnt) begin
                // The request just accepted belongs to the old stream.
                state_d = StWait;
                stale_d = 1'b1;
            end else begin
                state_d = StReq;
                stale_d = 1'b0;
            end
        end else begin
            unique case (state_q)
                StReq: begin
                    if (bus.mem_req && bus.mem_gnt) begin
                        state_d  = StWait;
                        req_pc_d = pc_q;
                    end
                end
                StWait: begin
                    if (bus.mem_rvalid) begin
                        if (stale_q) begin
                            stale_d = 1'b0;
                            state_d = StReq;
                        end else begin
                            push = 1'b1;
                            if (fetch_word == 32'h0) begin
                                halted_d = 1'b1;
                                state_d  = StHalt;
                            end else begin
                                pc_d    = fetch_npc;
                                state_d = StReq;
                            end
                        end
                    end
                end
                StHalt: begin
                    state_d = StHalt;
                end
                default: begin
                    state_d = StReq;
                end
            endcase
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            count_d = count_q + CntW'(push) - CntW'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StReq;
            pc_q      <= RESET_PC;
            req_pc_q  <= 64'h0;
            stale_q   <= 1'b0;
            halted_q  <= 1'b0;
            started_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            req_pc_q  <= req_pc_d;
            stale_q   <= stale_d;
            halted_q  <= halted_d;
            // Hold off the first request one cycle so outputs stay quiet across reset release.
            started_q <= 1'b1;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                instr_q[i] <= 32'h0;
                npc_q[i]   <= 64'h0;
            end
        end else if (push) begin
            instr_q[wr_ptr_q] <= fetch_word;
            npc_q[wr_ptr_q]   <= fetch_npc;
        end
    end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
Instruction fetch stage that produces the IF/ID stream consumed by the decode stage: instr_reg, ifid_npc and data_ack.
- Issues 64-bit-aligned reads to the instruction memory port and selects the 32-bit word.
- Buffers fetched instructions in a 2-entry FIFO.
- Handles decode back-pressure, branch/jump redirects, and halts on the all-zero instruction.

Parameters:
RESET_PC, 64'h0, PC loaded on reset.
FIFO_DEPTH, 2, instruction buffer entries; power of two, at least 2.

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
mem_req  output  1  read request valid
mem_addr  output  64  request address, bits [2:0] always zero
mem_gnt  input  1  request accepted this cycle
mem_rvalid  input  1  read data valid
mem_rdata  input  64  read data, little-endian
id_ready  input  1  decode consumes the head entry this cycle
redirect_valid  input  1  redirect fetch (taken branch, jal, jalr)
redirect_pc  input  64  redirect target; bits [1:0] ignored
instr_reg  output  32  head instruction
ifid_npc  output  64  PC of head instruction + 4
data_ack  output  1  head entry valid
halted  output  1  zero instruction fetched, fetch stopped

Behaviour:
Reset (reset==0, asynchronous): all outputs 0; pc=RESET_PC; FIFO empty; state=REQ; stale=0.

State machine (one outstanding request maximum):
- REQ: mem_req=1 when the FIFO has a free slot not reserved by an in-flight request, and not halted. mem_addr={pc[63:3],3'b0}. On mem_gnt go to WAIT and latch pc into req_pc.
- WAIT: mem_req=0. On mem_rvalid:
  - if stale==0, push {instr, req_pc+4}, where instr = req_pc[2] ? mem_rdata[63:32] : mem_rdata[31:0];
  - then pc=req_pc+4 and go to REQ.
  - if stale==1, discard the data, clear stale, go to REQ.
- HALT: mem_req=0 until a redirect or reset.

Zero instruction:
- A pushed instr==32'h0 is still delivered to decode.
- Set halted=1 and enter HALT; pc is not advanced.

Output side:
- instr_reg, ifid_npc and data_ack reflect the FIFO head combinationally from registered state.
- Pop when data_ack && id_ready.
- Zero-latency bypass is not allowed: data arriving in cycle N is visible on data_ack at cycle N+1 at the earliest.

Redirect (highest priority over all other events in that cycle):
- Flush the FIFO; data_ack=0 next cycle.
- pc={redirect_pc[63:2],2'b00}; halted=0.
- If in WAIT with no mem_rvalid this cycle, set stale=1 and stay in WAIT; otherwise go to REQ.
- A redirect coinciding with mem_rvalid discards that data.
- A redirect coinciding with mem_gnt marks that request stale.
- A same-cycle pop is ignored.

FIFO:
- Simultaneous push and pop when full: not possible, because issue reserves a slot.
- Simultaneous push and pop otherwise: count unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- Pop while empty: no effect.

Arithmetic: PC arithmetic is 64-bit unsigned and wraps at 2^64 (e.g. pc=64'hFFFF_FFFF_FFFF_FFFC yields npc=0).

Throughput: with mem_gnt tied 1 and mem_rvalid one cycle after grant, one instruction per 2 cycles.

Test Plan:
- Reset release, memory holds 64'h00500093_00100093 at addr 0, id_ready=1 -> instr_reg 32'h00100093 with ifid_npc 4, then 32'h00500093 with ifid_npc 8; first data_ack no earlier than 3 cycles after reset deassert.
- id_ready=0 with sequential fetch -> exactly 2 entries buffered; mem_req stays 0; raising id_ready drains in order without loss or duplication.
- Redirect to 64'h1004 while in WAIT; old response (rdata 64'hDEADBEEF_CAFEF00D) arrives next cycle -> old response dropped; next delivered instr is upper word of addr 64'h1000 with ifid_npc 64'h1008.
- Fetch of 32'h00000000 at pc 0x10 -> delivered with ifid_npc 0x14; halted=1; no further mem_req; redirect to 0x40 clears halted and fetching resumes at 0x40.
- Asynchronous reset asserted mid-WAIT, between clock edges -> outputs 0 immediately; after release, the first mem_addr is RESET_PC.
- Redirect in the same cycle as mem_rvalid and a pop -> data discarded, FIFO empty, next mem_addr is the redirect target aligned to 8.
